// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the FSM state type, the RISC-V funct3 width codes, the access-size
// decode and the funct3 legality check that depends on the data bus width.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP,
    ST_ERR
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access size in bytes; the low two funct3 bits encode log2(size).
  function automatic logic [3:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Doubleword and unsigned-word accesses only exist on a 64-bit bus.
  function automatic logic f3_legal(input logic [2:0] f3, input int unsigned dw);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
      F3_D, F3_WU:                    return (dw == 32'd64);
      default:                        return 1'b0;
    endcase
  endfunction

  // B/H/W/D sign-extend, the U variants zero-extend.
  function automatic logic f3_signed(input logic [2:0] f3);
    return ~f3[2];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Per-beat lane alignment for the load/store unit (purely combinational).
// Ports:
//   lane      byte lane of the effective address within a bus word
//   f3        funct3 width code (size and signedness)
//   hi_beat   0 = produce beat0 (low word) values, 1 = beat1 (next word)
//   st_data   store source value; only its low `size` bytes are used
//   ld_lo     read data of the word holding the first byte of the access
//   ld_hi     read data of the following word (same as ld_lo if not split)
//   be        byte enables for the selected beat
//   wr_data   lane-positioned store data for the selected beat
//   ld_result load value extracted from ld_lo/ld_hi and extended to DW
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DW = 32,
  localparam int NB = DW / 8,
  localparam int LW = $clog2(NB)
) (
  input  logic [LW-1:0] lane,
  input  logic [2:0]    f3,
  input  logic          hi_beat,
  input  logic [DW-1:0] st_data,
  input  logic [DW-1:0] ld_lo,
  input  logic [DW-1:0] ld_hi,
  output logic [NB-1:0] be,
  output logic [DW-1:0] wr_data,
  output logic [DW-1:0] ld_result
);

  logic [3:0]      size;
  logic [NB-1:0]   size_mask;
  logic [DW-1:0]   st_masked;
  logic [2*NB-1:0] be_wide;
  logic [2*DW-1:0] st_wide;
  logic [2*DW-1:0] ld_cat;
  logic [DW-1:0]   ld_bytes;
  logic            sign_bit;
  logic            ext_bit;

  assign size   = f3_size(f3);
  assign ld_cat = {ld_hi, ld_lo};

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign size_mask[gi]        = (32'(gi) < {28'd0, size});
      assign st_masked[8*gi +: 8] = size_mask[gi] ? st_data[8*gi +: 8] : 8'h00;
      // Result byte gi comes from byte (lane + gi) of the two-word window.
      assign ld_bytes[8*gi +: 8]  = ld_cat[8*(32'(lane) + gi) +: 8];
      assign ld_result[8*gi +: 8] = size_mask[gi] ? ld_bytes[8*gi +: 8] : {8{ext_bit}};
    end
  endgenerate

  // Shift into a two-word window: the low half is beat0, the high half is
  // whatever spilled over into the next word (beat1).
  assign be_wide = {{NB{1'b0}}, size_mask} << lane;
  assign st_wide = {{DW{1'b0}}, st_masked} << {lane, 3'b000};

  assign be      = hi_beat ? be_wide[2*NB-1:NB] : be_wide[NB-1:0];
  assign wr_data = hi_beat ? st_wide[2*DW-1:DW] : st_wide[DW-1:0];

  always_comb begin
    sign_bit = ld_bytes[DW-1];
    case (size)
      4'd1:    sign_bit = ld_bytes[7];
      4'd2:    sign_bit = ld_bytes[15];
      4'd4:    sign_bit = ld_bytes[31];
      default: sign_bit = ld_bytes[DW-1];
    endcase
  end

  assign ext_bit = sign_bit & f3_signed(f3);

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one load/store per handshake from execute,
// forms base+offset, drives the data-bus request/ready interface (one beat,
// or two beats for word-crossing accesses when MISALIGN_EN=1) and returns
// the extended load result for writeback.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   ex_valid/ex_ready              op handshake from execute
//   op_load, op_store, funct3      operation kind and width code
//   base, offset, st_data          address operands and store source
//   ls_done, ls_err                completion / error pulses
//   rd_we, rd_data                 load writeback strobe and value
//   d_addr, d_be, d_wr_data        registered bus beat address/enables/data
//   d_wr_req/d_wr_ready            store request / acceptance
//   d_rd_req/d_rd_ready, d_rd_data load request / response
module lsu
  import lsu_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            op_load,
  input  logic            op_store,
  input  logic [2:0]      funct3,
  input  logic [AW-1:0]   base,
  input  logic [AW-1:0]   offset,
  input  logic [DW-1:0]   st_data,
  output logic            ls_done,
  output logic            ls_err,
  output logic            rd_we,
  output logic [DW-1:0]   rd_data,
  output logic [AW-1:0]   d_addr,
  output logic [DW/8-1:0] d_be,
  output logic            d_wr_req,
  output logic            d_rd_req,
  output logic [DW-1:0]   d_wr_data,
  input  logic            d_wr_ready,
  input  logic            d_rd_ready,
  input  logic [DW-1:0]   d_rd_data
);

  localparam int NB = DW / 8;
  localparam int LW = $clog2(NB);

  state_t state_reg, state_next;

  logic [AW-1:0] ea;
  logic [LW-1:0] ea_lane;
  logic [3:0]    ea_size;
  logic          crosses;
  logic          accept;
  logic          bad_op;
  logic          bus_ack;
  logic          sel_live;

  logic          load_reg;
  logic          split_reg;
  logic [LW-1:0] lane_reg;
  logic [2:0]    f3_reg;
  logic [DW-1:0] st_data_reg;
  logic [DW-1:0] hold_reg;
  logic [DW-1:0] rd_data_reg;
  logic [AW-1:0] d_addr_reg;
  logic [NB-1:0] d_be_reg;
  logic [DW-1:0] d_wr_data_reg;
  logic          d_wr_req_reg;
  logic          d_rd_req_reg;

  logic [LW-1:0] a_lane;
  logic [2:0]    a_f3;
  logic [DW-1:0] a_st;
  logic [DW-1:0] a_ld_lo;
  logic [NB-1:0] a_be;
  logic [DW-1:0] a_wr;
  logic [DW-1:0] a_ld;

  assign ea      = base + offset;
  assign ea_lane = ea[LW-1:0];
  assign ea_size = f3_size(funct3);
  assign crosses = ({{(5-LW){1'b0}}, ea_lane} + {1'b0, ea_size}) > 5'(NB);
  assign accept  = (state_reg == ST_IDLE) & ex_valid & (op_load | op_store);
  assign bad_op  = ~f3_legal(funct3, DW) | (crosses & (MISALIGN_EN == 0));
  assign bus_ack = (d_wr_req_reg & d_wr_ready) | (d_rd_req_reg & d_rd_ready);

  // One aligner serves both beats: while idle it sees the live op so beat0
  // can be registered at accept; afterwards it sees the latched op and
  // produces beat1 values and the load result.
  assign sel_live = (state_reg == ST_IDLE);
  assign a_lane   = sel_live ? ea_lane : lane_reg;
  assign a_f3     = sel_live ? funct3 : f3_reg;
  assign a_st     = sel_live ? st_data : st_data_reg;
  assign a_ld_lo  = (state_reg == ST_BEAT1) ? hold_reg : d_rd_data;

  lsu_align #(.DW(DW)) u_align (
    .lane      (a_lane),
    .f3        (a_f3),
    .hi_beat   (~sel_live),
    .st_data   (a_st),
    .ld_lo     (a_ld_lo),
    .ld_hi     (d_rd_data),
    .be        (a_be),
    .wr_data   (a_wr),
    .ld_result (a_ld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ex_ready   = 1'b0;
    ls_done    = 1'b0;
    ls_err     = 1'b0;
    rd_we      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ex_ready = 1'b1;
        if (accept) begin
          state_next = bad_op ? ST_ERR : ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (bus_ack) begin
          state_next = split_reg ? ST_BEAT1 : ST_RESP;
        end
      end
      ST_BEAT1: begin
        if (bus_ack) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        ls_done    = 1'b1;
        rd_we      = load_reg;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        ls_done    = 1'b1;
        ls_err     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_reg      <= 1'b0;
      split_reg     <= 1'b0;
      lane_reg      <= '0;
      f3_reg        <= '0;
      st_data_reg   <= '0;
      hold_reg      <= '0;
      rd_data_reg   <= '0;
      d_addr_reg    <= '0;
      d_be_reg      <= '0;
      d_wr_data_reg <= '0;
      d_wr_req_reg  <= 1'b0;
      d_rd_req_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            load_reg    <= op_load;
            split_reg   <= crosses;
            lane_reg    <= ea_lane;
            f3_reg      <= funct3;
            st_data_reg <= st_data;
            if (!bad_op) begin
              d_addr_reg    <= {ea[AW-1:LW], {LW{1'b0}}};
              d_be_reg      <= a_be;
              d_wr_data_reg <= op_load ? '0 : a_wr;
              d_wr_req_reg  <= ~op_load;
              d_rd_req_reg  <= op_load;
            end
          end
        end
        ST_BEAT0: begin
          if (bus_ack) begin
            if (split_reg) begin
              // Move straight to the next word; the request stays high.
              d_addr_reg    <= d_addr_reg + AW'(NB);
              d_be_reg      <= a_be;
              d_wr_data_reg <= load_reg ? '0 : a_wr;
              hold_reg      <= d_rd_data;
            end else begin
              d_wr_req_reg <= 1'b0;
              d_rd_req_reg <= 1'b0;
              if (load_reg) begin
                rd_data_reg <= a_ld;
              end
            end
          end
        end
        ST_BEAT1: begin
          if (bus_ack) begin
            d_wr_req_reg <= 1'b0;
            d_rd_req_reg <= 1'b0;
            if (load_reg) begin
              rd_data_reg <= a_ld;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data   = rd_data_reg;
  assign d_addr    = d_addr_reg;
  assign d_be      = d_be_reg;
  assign d_wr_data = d_wr_data_reg;
  assign d_wr_req  = d_wr_req_reg;
  assign d_rd_req  = d_rd_req_reg;

endmodule

// File: doc/lsu.md
# lsu

Parametrised load/store unit that takes the memory half of the execute stage out of the core datapath. It accepts one load or store per handshake from execute, computes the effective address, and drives the data-bus request/ready interface. It generates byte enables and lane-shifted store data, and returns sign- or zero-extended load data for register writeback. Unlike the current in-line logic, it supports 32/64-bit data paths and splits misaligned accesses into two bus beats, or traps them when splitting is disabled.

## Interface
- DW, 32: data bus width in bits; 32 or 64.
- AW, 32: address width.
- MISALIGN_EN, 1: 1 = split boundary-crossing accesses into two beats; 0 = report them as errors.
- clk  in  1  clock; all state on rising edge. One clock.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute presents a memory op.
- ex_ready  out  1  unit idle and accepting; reset 1.
- op_load / op_store  in  1  operation kind; exactly one is high when ex_valid.
- funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- base, offset  in  AW  effective address = base + offset, modulo 2^AW.
- st_data  in  DW  store source register value.
- ls_done  out  1  one-cycle completion pulse; reset 0.
- ls_err  out  1  one-cycle pulse with ls_done for misaligned (MISALIGN_EN=0) or illegal funct3; reset 0.
- rd_we  out  1  load writeback strobe, coincident with ls_done; reset 0.
- rd_data  out  DW  extended load result, valid with rd_we; reset 0.
- d_addr  out  AW  word-aligned bus address; reset 0.
- d_be  out  DW/8  byte enables; reset 0.
- d_wr_req / d_rd_req  out  1  bus requests; reset 0.
- d_wr_data  out  DW  lane-positioned store data; reset 0.
- d_wr_ready / d_rd_ready  in  1  bus acceptance/response.
- d_rd_data  in  DW  read data, valid when d_rd_req & d_rd_ready.

## Operation
- Sizes: 1, 2, 4 and 8 bytes. Legal funct3 codes for DW=32: 000, 001, 010, 100, 101. DW=64 also allows 011 and 110. 111 is always illegal.
- Lane index L = addr[log2(DW/8)-1:0]. The access crosses a word boundary when L + size > DW/8.
- Aligned access: one beat at {addr[AW-1:log2(DW/8)], 0}, with be = size ones shifted left by L, and st_data low bytes shifted left by 8·L.
- Crossing access, MISALIGN_EN=1:
  - beat0 is at the aligned address and covers lanes L..DW/8-1.
  - beat1 is at aligned address + DW/8 and covers the remaining low lanes.
  - For loads, beat0 read data goes into a hold register; the result is assembled little-endian from both beats.
- Crossing access with MISALIGN_EN=0, or illegal funct3: no bus request is issued. ls_err and ls_done pulse and rd_we stays 0.
- Load extension: B, H and W are sign-extended to DW; BU, HU and WU are zero-extended.
- FSM states:
  - IDLE: ex_ready=1. On ex_valid & (op_load|op_store), latch the op. Go to ERR if error, else to BEAT0.
  - BEAT0: assert the request and hold addr/be/data stable until ready. On ready, go to BEAT1 if split, else to RESP.
  - BEAT1: same behaviour as BEAT0 for the second beat. On ready, go to RESP.
  - RESP: ls_done=1, rd_we=op_load. Go to IDLE.
  - ERR: ls_done=1, ls_err=1. Go to IDLE.
- ex_valid while busy is ignored; execute holds the op until ex_ready.
- A ready input without the matching request asserted is ignored.
- A store never asserts d_rd_req; a load never asserts d_wr_req.

## Timing
- Accept in cycle 0. The request is asserted from cycle 1, with d_addr, d_be and d_wr_data registered.
- Request stays high through wait states. At ready (split case), beat1 values appear at the next edge and the request stays high, with no idle gap.
- Zero-wait aligned access: ls_done in cycle 2. Split access: ls_done in cycle 3. Error: ls_done in cycle 1.
- Each bus wait cycle adds one cycle to the latency.
- Earliest next accept: the cycle after ls_done, so throughput is 1 op / 3 cycles for aligned zero-wait accesses.
- rst asserted mid-operation:
  - Requests, FSM and outputs return to reset values asynchronously.
  - The pending op is dropped and no ls_done is issued.
  - ex_ready is 1 while rst is high.

## Structure
- lsu_pkg holds the state enum, funct3 width constants, size-decode function and the DW legality check.
- Sub-module lsu_align (combinational) handles per-beat be and store shift generation, plus load byte extraction and extension. The lsu top holds the FSM, address adder and hold register.

## Test plan
- DW=32, SW base 0x100 + offset 4, data 0xDEADBEEF, zero wait → d_addr 0x104, be 0xF, d_wr_data 0xDEADBEEF, ls_done in cycle 2.
- LB at 0x203, d_rd_data 0x80123456 → rd_data 0xFFFFFF80. Same with LBU → 0x00000080.
- LW at 0x102, MISALIGN_EN=1:
  - beat0 at 0x100, be 0xC, read data 0x11223344.
  - beat1 at 0x104, be 0x3, read data 0x55667788.
  - Result: rd_data 0x77881122, ls_done in cycle 3.
- SH at 0x103, data 0xABCD:
  - beat0 at 0x100, be 0x8, d_wr_data 0xCD000000.
  - beat1 at 0x104, be 0x1, d_wr_data 0x000000AB.
- MISALIGN_EN=0, LW at 0x101 → no request; ls_err and ls_done pulse in cycle 1; rd_we=0. Repeat with funct3=011 at DW=32 → same response.
- Load with d_rd_ready held low 5 cycles → d_rd_req and d_addr stable throughout. Then assert rst in the 3rd wait cycle → d_rd_req=0 immediately, no ls_done, ex_ready=1.
